// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the nibble-serial carry-lookahead adder.
//   NIBBLE_W : width of one adder slice (4 bits)
//   state_t  : sequencer states IDLE / RUN / DRAIN / DONE
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cla_nibble_serial_adder_cla4.sv
// -----------------------------------------------------------------------------
// four_bit_carry_lookahead_adder
// One 4-bit carry-lookahead slice with registered sum and carry outputs.
// Outputs update only on edges where i_en is high, so the caller can read
// the previous nibble's result while presenting the next nibble.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   i_en            : load enable for the result registers
//   i_a, i_b        : operand nibbles
//   i_carry_in      : carry into bit 0
//   o_partial_sum   : registered 4-bit sum
//   o_carry_out     : registered carry out of bit 3
//   o_done          : registered copy of i_en (result updated last edge)
// -----------------------------------------------------------------------------
module four_bit_carry_lookahead_adder
  import cla_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_carry_in,
  output logic [NIBBLE_W-1:0] o_partial_sum,
  output logic                o_carry_out,
  output logic                o_done
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;
  logic [NIBBLE_W-1:0] w_sum;

  logic [NIBBLE_W-1:0] r_sum;
  logic                r_cout;
  logic                r_done;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Flattened lookahead terms: every carry depends only on g, p and c0.
  assign w_c[0] = i_carry_in;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign w_sum = w_p ^ w_c[NIBBLE_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_en;
      if (i_en) begin
        r_sum  <= w_sum;
        r_cout <= w_c[NIBBLE_W];
      end
    end
  end

  assign o_partial_sum = r_sum;
  assign o_carry_out   = r_cout;
  assign o_done        = r_done;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_serial_adder
// WIDTH-bit adder that reuses a single 4-bit lookahead slice, one nibble per
// clock. Operands are captured on accept, walked LSB nibble first through the
// slice, and the registered partial sums are reassembled into out_sum.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// result stays stable until out_ready is seen.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   in_a, in_b, in_carry  : operands and carry into nibble 0
//   out_valid / out_ready : result handshake
//   out_sum, out_carry    : (A+B+cin) mod 2^WIDTH and the carry out of the MSB
//   busy                  : sequencer not in IDLE
//   out_ovf               : signed overflow (only with CLA_SERIAL_OVERFLOW_EN)
//
// Optional macro: CLA_SERIAL_OVERFLOW_EN adds the out_ovf port and its logic.
// Timing: out_valid rises NUM_NIB+1 edges after accept; back-to-back rate is
// one op every NUM_NIB+3 cycles.
// -----------------------------------------------------------------------------
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
`ifdef CLA_SERIAL_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NUM_NIB = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NUM_NIB);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;

  logic [IDX_W-1:0]    w_prev_idx;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic                w_slice_en;
  logic                w_slice_cin;
  logic [NIBBLE_W-1:0] w_slice_sum;
  logic                w_slice_cout;
  logic                w_slice_done;

  // Nibble select: {idx, 2'b00} is 4*idx without a multiplier.
  assign w_a_nib    = r_a[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_b_nib    = r_b[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_prev_idx = r_idx - IDX_ONE;

  // The slice registers its carry, so chaining it back in is the ripple
  // between nibbles; nibble 0 takes the captured carry-in instead.
  assign w_slice_cin = (r_idx == '0) ? r_cin : w_slice_cout;
  assign w_slice_en  = (r_state == RUN);

  four_bit_carry_lookahead_adder u_slice (
    .clk           (clk),
    .reset         (reset),
    .i_en          (w_slice_en),
    .i_a           (w_a_nib),
    .i_b           (w_b_nib),
    .i_carry_in    (w_slice_cin),
    .o_partial_sum (w_slice_sum),
    .o_carry_out   (w_slice_cout),
    .o_done        (w_slice_done)   // sequencing is tracked by r_idx instead
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_cin   <= in_carry;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Slice output now holds the result for the previous nibble.
          if (r_idx != '0) begin
            r_sum[{w_prev_idx, 2'b00} +: NIBBLE_W] <= w_slice_sum;
          end
          if (r_idx == IDX_LAST) begin
            r_idx   <= '0;
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        DRAIN: begin
          r_sum[WIDTH-1 -: NIBBLE_W] <= w_slice_sum;
          r_carry                    <= w_slice_cout;
          r_state                    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CLA_SERIAL_OVERFLOW_EN
  logic r_ovf;

  // Carry into the MSB is recovered from the MSB sum bit and operand bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (r_state == DRAIN) begin
      r_ovf <= (w_slice_sum[NIBBLE_W-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1]) ^ w_slice_cout;
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_sum;
  assign out_carry = r_carry;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_serial_adder
// Directed and random checks of the nibble-serial adder against a plain
// arithmetic reference. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_cla_nibble_serial_adder;

  localparam int WIDTH   = 32;
  localparam int NUM_NIB = WIDTH / 4;
  localparam int LAT     = NUM_NIB + 1;
  localparam int SPACING = NUM_NIB + 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;
`ifdef CLA_SERIAL_OVERFLOW_EN
  logic             out_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // {ovf, carry, sum}
  logic [WIDTH+1:0] exp_q[$];

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
`ifdef CLA_SERIAL_OVERFLOW_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] full;
    logic           ovf;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // Signed overflow: like-signed operands giving a differently signed sum.
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full};
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    return {$urandom(), $urandom()} >> (64 - WIDTH);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check_result(input string name, input logic [WIDTH+1:0] exp);
    checks++;
    if (out_sum !== exp[WIDTH-1:0]) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, out_sum, exp[WIDTH-1:0]);
    end
    checks++;
    if (out_carry !== exp[WIDTH]) begin
      errors++;
      $display("FAIL %s carry: got %b expected %b", name, out_carry, exp[WIDTH]);
    end
`ifdef CLA_SERIAL_OVERFLOW_EN
    checks++;
    if (out_ovf !== exp[WIDTH+1]) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, out_ovf, exp[WIDTH+1]);
    end
`endif
  endtask

  // Waits for out_valid after an accept edge; returns edges counted.
  task automatic wait_result(input string name, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || lat != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0d) expected %0d", name, lat, got, LAT);
    end
  endtask

  task automatic handshake_out(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post-handshake: got valid=%b ready=%b busy=%b expected 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  // Full single operation starting from IDLE.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
    int lat;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
    end
    in_a = a; in_b = b; in_carry = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = rnd_word(); in_b = rnd_word(); in_carry = 1'($urandom_range(0, 1));
    wait_result(name, lat);
    check_result(name, model(a, b, cin));
    handshake_out(name);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got ready=%b valid=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_sum !== '0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset result: got sum=%h carry=%b expected 0 0", out_sum, out_carry);
    end
  endtask

  task automatic test_directed();
    run_op("carry_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("cin_only",   32'h0000_0000, 32'h0000_0000, 1'b1);
    run_op("mixed",      32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    // Anchor the model on the documented vectors as well.
    checks++;
    if (model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0) !== {2'b00, 32'hACF1_3568}) begin
      errors++;
      $display("FAIL model_anchor: got %h expected %h",
               model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0), {2'b00, 32'hACF1_3568});
    end
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 4; i++) begin
      run_op("rand_single", rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic [WIDTH+1:0] e1;
    int lat;
    a1 = rnd_word(); b1 = rnd_word();
    a2 = ~a1;        b2 = b1 ^ 32'h5A5A_5A5A;
    e1 = model(a1, b1, 1'b1);
    in_a = a1; in_b = b1; in_carry = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("hold_first", lat);
    // New operands offered while the result waits.
    in_a = a2; in_b = b2; in_carry = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold flags: got valid=%b ready=%b expected 1 0", out_valid, in_ready);
      end
      check_result("hold_stable", e1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold no-same-cycle-accept: got ready=%b valid=%b expected 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold second accept: got busy=%b expected 1", busy);
    end
    wait_result("hold_second", lat);
    check_result("hold_second", model(a2, b2, 1'b0));
    handshake_out("hold_second");
  endtask

  task automatic test_reset_mid_run();
    in_a = rnd_word(); in_b = rnd_word(); in_carry = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun async reset: got valid=%b ready=%b busy=%b expected 0 1 0",
               out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        out_sum !== '0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL midrun after release: got valid=%b ready=%b busy=%b sum=%h carry=%b expected 0 1 0 0 0",
               out_valid, in_ready, busy, out_sum, out_carry);
    end
    run_op("after_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    int issued, recv, prev_acc, budget;
    logic [WIDTH+1:0] exp;
    issued = 0; recv = 0; prev_acc = -1; budget = 0;
    exp_q.delete();
    in_a = rnd_word(); in_b = rnd_word(); in_carry = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'b1;
    while (recv < 20 && budget < 20 * SPACING + 60) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b unexpected result: got sum=%h expected none", out_sum);
        end else begin
          exp = exp_q.pop_front();
          check_result("b2b", exp);
        end
        recv++;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        exp_q.push_back(model(in_a, in_b, in_carry));
        if (prev_acc >= 0) begin
          checks++;
          if (cyc - prev_acc != SPACING) begin
            errors++;
            $display("FAIL b2b spacing: got %0d expected %0d", cyc - prev_acc, SPACING);
          end
        end
        prev_acc = cyc;
        issued++;
      end else begin
        in_a = rnd_word(); in_b = rnd_word(); in_carry = 1'($urandom_range(0, 1));
        in_valid = (issued < 20);
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (recv != 20 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b completion: got %0d results (%0d pending) expected 20 (0)",
               recv, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random_single();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
